// File: rtl/serial_checker_sink.sv
// Serial flit receiver: assembles fixed-length packets, checks the destination
// against ID and flags framing errors. Statistics counters exist only with SINK_STATS_EN.
module serial_checker_sink #(
  parameter int ID          = 0,
  parameter int SIZE        = 8,
  parameter int ADDR_BITS   = 4,
  parameter int PKT_FLITS   = 4,
  parameter int HOSP_PERIOD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 busy,
  input  logic                 data,
  output logic                 pkt_valid,
  output logic [ADDR_BITS-1:0] pkt_dest,
  output logic                 pkt_ok,
  output logic                 err_framing,
  output logic [15:0]          rx_pkt_count,
  output logic [15:0]          err_count
);

  localparam int BW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int IW = $clog2(PKT_FLITS);
  localparam int TW = (HOSP_PERIOD > 2) ? $clog2(HOSP_PERIOD) : 1;
  localparam logic [BW-1:0]        BIT_LAST = BW'(SIZE - 1);
  localparam logic [IW-1:0]        IDX_LAST = IW'(PKT_FLITS - 1);
  localparam logic [TW-1:0]        THR_LAST = TW'(HOSP_PERIOD - 1);
  localparam logic [ADDR_BITS-1:0] MY_ID    = ADDR_BITS'(ID);
  localparam bit                   THR_EN   = (HOSP_PERIOD >= 2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_STORE = 2'd2
  } state_t;

  state_t               state_q;
  logic                 busy_q;
  logic [BW-1:0]        bit_cnt_q;
  logic [IW-1:0]        flit_idx_q;
  logic [TW-1:0]        thr_cnt_q, thr_cnt_d;
  logic [SIZE-1:0]      shift_q;
  logic [ADDR_BITS-1:0] hdr_dest_q;
  logic                 pkt_valid_q, pkt_ok_q, err_framing_q;
  logic [ADDR_BITS-1:0] pkt_dest_q;
  logic                 thr_next_s, pkt_done_s;

  // Throttle counter next value and packet-completion decode for this cycle
  always_comb begin
    if (THR_EN && (thr_cnt_q != THR_LAST)) begin
      thr_cnt_d = thr_cnt_q + TW'(1);
    end else begin
      thr_cnt_d = {TW{1'b0}};
    end
    thr_next_s = THR_EN && (thr_cnt_d == THR_LAST);
    pkt_done_s = (state_q == S_STORE) && !data && (flit_idx_q == IDX_LAST);
  end

  // Receive FSM; busy is registered from the next state so it is exact in its own cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      busy_q        <= 1'b0;
      bit_cnt_q     <= {BW{1'b0}};
      flit_idx_q    <= {IW{1'b0}};
      thr_cnt_q     <= {TW{1'b0}};
      shift_q       <= {SIZE{1'b0}};
      hdr_dest_q    <= {ADDR_BITS{1'b0}};
      pkt_valid_q   <= 1'b0;
      pkt_dest_q    <= {ADDR_BITS{1'b0}};
      pkt_ok_q      <= 1'b0;
      err_framing_q <= 1'b0;
    end else begin
      thr_cnt_q     <= thr_cnt_d;
      pkt_valid_q   <= 1'b0;
      err_framing_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (data && !busy_q) begin
            state_q   <= S_SHIFT;
            bit_cnt_q <= {BW{1'b0}};
            busy_q    <= 1'b1;
          end else begin
            busy_q    <= thr_next_s;
          end
        end
        S_SHIFT: begin
          shift_q <= {data, shift_q[SIZE-1:1]};
          busy_q  <= 1'b1;
          if (bit_cnt_q == BIT_LAST) begin
            state_q <= S_STORE;
          end else begin
            bit_cnt_q <= bit_cnt_q + BW'(1);
          end
        end
        S_STORE: begin
          state_q <= S_IDLE;
          busy_q  <= thr_next_s;
          if (data) begin
            // line still high after the last data bit: drop the partial packet
            err_framing_q <= 1'b1;
            flit_idx_q    <= {IW{1'b0}};
          end else begin
            if (flit_idx_q == {IW{1'b0}}) begin
              hdr_dest_q <= shift_q[ADDR_BITS-1:0];
            end
            if (pkt_done_s) begin
              flit_idx_q  <= {IW{1'b0}};
              pkt_valid_q <= 1'b1;
              pkt_dest_q  <= hdr_dest_q;
              pkt_ok_q    <= (hdr_dest_q == MY_ID);
            end else begin
              flit_idx_q  <= flit_idx_q + IW'(1);
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= thr_next_s;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign pkt_valid   = pkt_valid_q;
  assign pkt_dest    = pkt_dest_q;
  assign pkt_ok      = pkt_ok_q;
  assign err_framing = err_framing_q;

`ifdef SINK_STATS_EN
  logic [15:0] rx_cnt_q, rx_cnt_d, err_cnt_q, err_cnt_d;
  logic        miss_s, frame_s;
  logic [1:0]  err_inc_s;
  logic [16:0] err_sum_s;

  // Saturating counters, updated on the same edge that raises pkt_valid/err_framing
  always_comb begin
    frame_s   = (state_q == S_STORE) && data;
    miss_s    = pkt_done_s && (hdr_dest_q != MY_ID);
    err_inc_s = {1'b0, miss_s} + {1'b0, frame_s};
    err_sum_s = {1'b0, err_cnt_q} + {15'd0, err_inc_s};
    if (pkt_done_s && (rx_cnt_q != 16'hFFFF)) begin
      rx_cnt_d = rx_cnt_q + 16'd1;
    end else begin
      rx_cnt_d = rx_cnt_q;
    end
    if (err_sum_s[16]) begin
      err_cnt_d = 16'hFFFF;
    end else begin
      err_cnt_d = err_sum_s[15:0];
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_cnt_q  <= 16'd0;
      err_cnt_q <= 16'd0;
    end else begin
      rx_cnt_q  <= rx_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign rx_pkt_count = rx_cnt_q;
  assign err_count    = err_cnt_q;
`else
  assign rx_pkt_count = 16'd0;
  assign err_count    = 16'd0;
`endif

endmodule

// File: tb/tb_serial_checker_sink.sv
// Self-checking bench for serial_checker_sink: directed table, throttle and reset
// sequences, and randomized packets scored against a packet-level model.
module tb_serial_checker_sink;

`ifdef SINK_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        data = 1'b0;
  logic        data2 = 1'b0;
  logic        busy, pkt_valid, pkt_ok, err_framing;
  logic [3:0]  pkt_dest;
  logic [15:0] rx_pkt_count, err_count;
  logic        busy2, pkt_valid2, pkt_ok2, err_framing2;
  logic [3:0]  pkt_dest2;
  logic [15:0] rx_pkt_count2, err_count2;

  serial_checker_sink #(.ID(5), .SIZE(8), .ADDR_BITS(4), .PKT_FLITS(4), .HOSP_PERIOD(0)) dut1 (
    .clk(clk), .reset(reset), .busy(busy), .data(data), .pkt_valid(pkt_valid),
    .pkt_dest(pkt_dest), .pkt_ok(pkt_ok), .err_framing(err_framing),
    .rx_pkt_count(rx_pkt_count), .err_count(err_count));

  serial_checker_sink #(.ID(5), .SIZE(8), .ADDR_BITS(4), .PKT_FLITS(4), .HOSP_PERIOD(4)) dut2 (
    .clk(clk), .reset(reset), .busy(busy2), .data(data2), .pkt_valid(pkt_valid2),
    .pkt_dest(pkt_dest2), .pkt_ok(pkt_ok2), .err_framing(err_framing2),
    .rx_pkt_count(rx_pkt_count2), .err_count(err_count2));

  always #5 clk = ~clk;

  typedef struct {
    logic        pv;
    logic        fe;
    logic [3:0]  dest;
    logic        ok;
    logic [15:0] rx;
    logic [15:0] err;
  } exp_t;

  typedef struct {
    logic [7:0]  hdr;
    int          frame_at;
    logic        pv;
    logic [3:0]  dest;
    logic        ok;
    logic [15:0] rx;
    logic [15:0] err;
  } row_t;

  int n_tests = 0, n_fail = 0, cyc = 0, stray = 0;
  int n_pv = 0, n_fe = 0, t0 = 0, t_valid = 0;
  bit pend = 0;
  exp_t pe;

  // packet-level reference model
  logic [7:0] m_q[$];
  logic [3:0] m_dest = 4'd0;
  logic       m_ok = 1'b0;
  int         m_rx = 0, m_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] sat16(input int v);
    return (v > 65535) ? 16'hFFFF : 16'(v);
  endfunction

  function automatic void model_reset();
    m_q.delete();
    m_dest = 4'd0;
    m_ok   = 1'b0;
    m_rx   = 0;
    m_err  = 0;
  endfunction

  function automatic exp_t model_flit(input logic [7:0] fl, input logic fr);
    exp_t e;
    e.pv = 1'b0;
    e.fe = fr;
    if (fr) begin
      m_q.delete();
      m_err++;
    end else begin
      m_q.push_back(fl);
      if (m_q.size() == 4) begin
        m_dest = m_q[0][3:0];
        m_ok   = (m_dest == 4'd5);
        m_rx++;
        if (!m_ok) m_err++;
        e.pv = 1'b1;
        m_q.delete();
      end
    end
    e.dest = m_dest;
    e.ok   = m_ok;
    e.rx   = STATS ? sat16(m_rx) : 16'd0;
    e.err  = STATS ? sat16(m_err) : 16'd0;
    return e;
  endfunction

  // one clock: sample outputs at the falling edge, score a pending flit, then drive
  task automatic tick(input logic d);
    @(negedge clk);
    cyc++;
    if (pend) begin
      pend = 0;
      check("pkt_valid", pkt_valid, pe.pv);
      check("err_framing", err_framing, pe.fe);
      check("pkt_dest", pkt_dest, pe.dest);
      check("pkt_ok", pkt_ok, pe.ok);
      check("rx_pkt_count", rx_pkt_count, pe.rx);
      check("err_count", err_count, pe.err);
      if (pkt_valid) begin
        n_pv++;
        t_valid = cyc;
      end
      if (err_framing) n_fe++;
    end else if (pkt_valid || err_framing) begin
      stray++;
    end
    data = d;
  endtask

  task automatic send_flit(input logic [7:0] fl, input logic fr, input exp_t e, input bit rel);
    tick(1'b1);
    if (rel) reset = 1'b1;
    for (int i = 0; i < 8; i++) tick(fl[i]);
    tick(fr);
    pe   = e;
    pend = 1;
  endtask

  task automatic send_pkt(input logic [7:0] hdr, input int frame_at, input int gap_max, input bit rel);
    for (int f = 0; f < 4; f++) begin
      logic [7:0] fl;
      logic       fr;
      exp_t       e;
      fl = (f == 0) ? hdr : 8'($urandom_range(0, 255));
      fr = (f == frame_at);
      e  = model_flit(fl, fr);
      send_flit(fl, fr, e, rel && (f == 0));
      repeat ($urandom_range(0, gap_max)) tick(1'b0);
      if (fr) break;
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_busy", busy, 1'b0);
    check("rst_pkt_valid", pkt_valid, 1'b0);
    check("rst_pkt_dest", pkt_dest, 4'd0);
    check("rst_pkt_ok", pkt_ok, 1'b0);
    check("rst_err_framing", err_framing, 1'b0);
    check("rst_rx_count", rx_pkt_count, 16'd0);
    check("rst_err_count", err_count, 16'd0);
  endtask

  row_t tbl[6];

  initial begin
    tbl[0] = '{8'h05, -1, 1'b1, 4'h5, 1'b1, 16'd1, 16'd0};
    tbl[1] = '{8'h03, -1, 1'b1, 4'h3, 1'b0, 16'd2, 16'd1};
    tbl[2] = '{8'h05,  2, 1'b0, 4'h3, 1'b0, 16'd2, 16'd2};
    tbl[3] = '{8'h35, -1, 1'b1, 4'h5, 1'b1, 16'd3, 16'd2};
    tbl[4] = '{8'h0F,  0, 1'b0, 4'h5, 1'b1, 16'd3, 16'd3};
    tbl[5] = '{8'hAA, -1, 1'b1, 4'hA, 1'b0, 16'd4, 16'd4};

    // reset state
    repeat (3) begin
      tick(1'b0);
      check_reset_outputs();
      check("rst_busy2", busy2, 1'b0);
    end
    tick(1'b0);
    reset = 1'b1;

    // throttle: busy on every 4th cycle after release; start bit on that cycle ignored
    for (int k = 1; k <= 16; k++) begin
      tick(1'b0);
      check("thr_busy", busy2, (k % 4) == 3);
      data2 = (k == 7);
    end
    tick(1'b0);
    check("thr_busy", busy2, 1'b0);
    data2 = 1'b1;
    tick(1'b0);
    check("thr_start_taken", busy2, 1'b1);
    data2 = 1'b0;
    repeat (12) tick(1'b0);

    // directed packets from the table
    for (int r = 0; r < 6; r++) begin
      n_pv = 0;
      n_fe = 0;
      t0   = cyc + 1;
      send_pkt(tbl[r].hdr, tbl[r].frame_at, 0, 1'b0);
      tick(1'b0);
      check("tbl_pkt_valid", n_pv, tbl[r].pv);
      check("tbl_err_framing", n_fe, tbl[r].frame_at >= 0);
      check("tbl_pkt_dest", pkt_dest, tbl[r].dest);
      check("tbl_pkt_ok", pkt_ok, tbl[r].ok);
      check("tbl_rx_count", rx_pkt_count, STATS ? tbl[r].rx : 16'd0);
      check("tbl_err_count", err_count, STATS ? tbl[r].err : 16'd0);
      if (r == 0) check("tbl_latency", t_valid - t0, 40);
    end

    // randomized packets with gaps and occasional framing errors
    for (int n = 0; n < 60; n++) begin
      logic [7:0] h;
      int         fa;
      h = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) h[3:0] = 4'd5;
      fa = ($urandom_range(0, 9) < 2) ? int'($urandom_range(0, 3)) : -1;
      send_pkt(h, fa, 2, 1'b0);
    end
    tick(1'b0);

    // reset in the middle of flit 1, then a fresh packet from the first cycle
    begin
      exp_t e;
      e = model_flit(8'h0A, 1'b0);
      send_flit(8'h0A, 1'b0, e, 1'b0);
    end
    tick(1'b1);
    for (int i = 0; i < 4; i++) tick(1'b1);
    #2 reset = 1'b0;
    #1 check_reset_outputs();
    model_reset();
    pend = 0;
    repeat (2) begin
      tick(1'b0);
      check_reset_outputs();
    end
    n_pv = 0;
    t0   = cyc + 1;
    send_pkt(8'h05, -1, 0, 1'b1);
    tick(1'b0);
    check("rst_after_pkt", n_pv, 1);
    check("rst_after_latency", t_valid - t0, 40);
    check("rst_after_rx", rx_pkt_count, STATS ? 16'd1 : 16'd0);

`ifdef SINK_STATS_EN
    // err_count saturation
    tick(1'b0);
    force dut1.err_cnt_d = 16'hFFFE;
    tick(1'b0);
    release dut1.err_cnt_d;
    check("sat_preload", err_count, 16'hFFFE);
    m_err = 65534;
    send_pkt(8'h03, -1, 0, 1'b0);
    send_pkt(8'h05, 0, 0, 1'b0);
    tick(1'b0);
    check("sat_final", err_count, 16'hFFFF);
    check("sat_rx", rx_pkt_count, 16'd2);
`else
    check("nostats_rx", rx_pkt_count, 16'd0);
    check("nostats_err", err_count, 16'd0);
`endif

    tick(1'b0);
    check("stray_pulses", stray, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
